regfile_ctx_ctrl: RTL and testbench
===================================

# regfile_ctx_ctrl

Context-switch sequencer for the 32×32 CPU register file. On an OS request it streams registers 1..31 of the register file out to a per-process slot in the backing store (save), or streams a slot back into the register file (restore), one register at a time over a req/ack memory handshake. It sits between the OS control logic, the register file's indexed HD port and the HD/memory controller. It stalls the CPU for the duration of the transfer.

## Interface
- NREGS, 32, register count; registers 1..NREGS-1 are transferred, r0 never touched
- IDXW, 5, register index width
- SLOTW, 5, process slot width; backing-store address = {slot, idx}
- TIMEOUT, 255, max cycles to wait for mem_ack before abort (8-bit counter)

- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start_save  in  1  pulse: begin save of register file to slot
- start_restore  in  1  pulse: begin restore of slot into register file
- slot  in  SLOTW  process slot, sampled on the accepted start
- busy  out  1  transfer in progress
- stall_cpu  out  1  equals busy; freezes PC/writeback
- done  out  1  1-cycle pulse at successful completion
- err  out  1  1-cycle pulse on timeout abort
- rf_idx  out  IDXW  register index presented to register file
- rf_rdata  in  32  register file read data at rf_idx (combinational)
- rf_wren  out  1  register file write enable (written on falling edge)
- rf_wdata  out  32  data to write at rf_idx
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write (save), 0 = read (restore)
- mem_addr  out  SLOTW+IDXW  {slot_q, rf_idx}
- mem_wdata  out  32  equals rf_rdata during save
- mem_ack  in  1  memory acknowledge; completes request on the rising edge it is sampled high
- mem_rdata  in  32  read data, valid when mem_ack high

## Operation
- States: IDLE, SAVE, RD_WAIT, RF_WR, FIN.
- IDLE: start_save accepted -> latch slot_q, idx=1, go SAVE. Else start_restore -> latch slot_q, idx=1, go RD_WAIT. Both high: save wins, restore dropped.
- Starts while not IDLE are ignored (no queuing).
- SAVE: mem_req=1, mem_we=1, mem_wdata=rf_rdata. On mem_ack: if idx==NREGS-1 go FIN, else idx+1, stay SAVE.
- RD_WAIT: mem_req=1, mem_we=0. On mem_ack: capture mem_rdata into rf_wdata register, go RF_WR.
- RF_WR: rf_wren=1 for exactly one cycle, mem_req=0. If idx==NREGS-1 go FIN, else idx+1, go RD_WAIT.
- FIN: done=1 for one cycle, busy=0 from next cycle, return IDLE.
- Timeout: wait counter clears on entry to SAVE/RD_WAIT and on each ack; increments each cycle mem_req=1 without ack. Reaching TIMEOUT -> err pulse, mem_req drops, go IDLE, no done. Register file partially updated on restore abort; this is permitted.
- busy=1 in SAVE, RD_WAIT, RF_WR, FIN's preceding cycles; busy=0 in IDLE and FIN.
- rf_idx = idx when busy, 0 otherwise; rf_wren=0 outside RF_WR.

## Timing
- Reset (async, any state): IDLE, idx=0, slot_q=0, counter=0; busy, stall_cpu, done, err, rf_wren, mem_req, mem_we = 0; rf_wdata, mem_addr = 0.
- Start sampled at edge N -> busy and mem_req high after edge N.
- Zero-wait memory (ack tied high): save = 31 cycles of SAVE + 1 FIN; restore = 62 cycles (RD_WAIT+RF_WR per register) + 1 FIN.
- Each wait cycle adds one cycle per register.
- rf_wren is a full clock high; register file commits on the falling edge inside RF_WR.
- mem_addr/mem_we/mem_wdata stable while mem_req high and ack low.

## Test plan
- Save, ack tied high, slot=3, regs preloaded ri=0x100+i -> mem writes addr 97..127 with data 0x101..0x11F, done at cycle 32, busy low after.
- Restore slot=3 with ack 2-cycle latency -> regs 1..31 rewritten from memory, r0 untouched, rf_wren exactly 31 pulses, done after 31×4+1 cycles.
- start_save and start_restore same cycle -> save performed only; start_restore during save ignored.
- mem_ack held low -> err pulse after 255 wait cycles, no done, busy=0 next cycle, mem_req=0.
- reset asserted mid-restore (idx=10) -> all outputs 0 immediately, IDLE; new start_save after release runs from idx=1.

Source files
------------

// File: rtl/regfile_ctx_ctrl.sv
// Context-switch sequencer: streams registers 1..NREGS-1 between the register file
// and a per-process slot in the backing store (save or restore), stalling the CPU meanwhile.
module regfile_ctx_ctrl #(
   parameter int NREGS   = 32,
   parameter int IDXW    = 5,
   parameter int SLOTW   = 5,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_save_i,
   input  logic                  start_restore_i,
   input  logic [SLOTW-1:0]      slot_i,
   output logic                  busy_o,
   output logic                  stall_cpu_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [IDXW-1:0]       rf_idx_o,
   input  logic [31:0]           rf_rdata_i,
   output logic                  rf_wren_o,
   output logic [31:0]           rf_wdata_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [SLOTW+IDXW-1:0] mem_addr_o,
   output logic [31:0]           mem_wdata_o,
   input  logic                  mem_ack_i,
   input  logic [31:0]           mem_rdata_i,
   output logic [2:0]            state_o
);

   // Memory handshake: mem_req_o is held with stable mem_addr_o/mem_we_o/mem_wdata_o until a
   // rising edge samples mem_ack_i high; that edge completes the transfer (mem_rdata_i valid then).

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SAVE    = 3'd1,
      S_RD_WAIT = 3'd2,
      S_RF_WR   = 3'd3,
      S_FIN     = 3'd4
   } state_t;

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREGS - 1);
   localparam logic [IDXW-1:0] FIRST_IDX = IDXW'(1);
   localparam logic [7:0]      TO_LAST  = 8'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [SLOTW-1:0] slot_q, slot_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [31:0]      wdata_q, wdata_d;

   logic waiting;
   logic timeout_hit;

   assign waiting     = (state_q == S_SAVE) || (state_q == S_RD_WAIT);
   // The cycle in which the counter would reach TIMEOUT is the last one spent waiting.
   assign timeout_hit = waiting && !mem_ack_i && (cnt_q == TO_LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         slot_q  <= '0;
         cnt_q   <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         slot_q  <= slot_d;
         cnt_q   <= cnt_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      slot_d  = slot_q;
      cnt_d   = cnt_q;
      wdata_d = wdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_save_i) begin
               slot_d  = slot_i;
               idx_d   = FIRST_IDX;
               cnt_d   = '0;
               state_d = S_SAVE;
            end else if (start_restore_i) begin
               slot_d  = slot_i;
               idx_d   = FIRST_IDX;
               cnt_d   = '0;
               state_d = S_RD_WAIT;
            end
         end
         S_SAVE: begin
            if (mem_ack_i) begin
               cnt_d = '0;
               if (idx_q == LAST_IDX) begin
                  state_d = S_FIN;
               end else begin
                  idx_d = idx_q + FIRST_IDX;
               end
            end else if (timeout_hit) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RD_WAIT: begin
            if (mem_ack_i) begin
               cnt_d   = '0;
               wdata_d = mem_rdata_i;
               state_d = S_RF_WR;
            end else if (timeout_hit) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RF_WR: begin
            cnt_d = '0;
            if (idx_q == LAST_IDX) begin
               state_d = S_FIN;
            end else begin
               idx_d   = idx_q + FIRST_IDX;
               state_d = S_RD_WAIT;
            end
         end
         S_FIN: begin
            idx_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      busy_o      = (state_q == S_SAVE) || (state_q == S_RD_WAIT) || (state_q == S_RF_WR);
      stall_cpu_o = busy_o;
      done_o      = (state_q == S_FIN);
      err_o       = timeout_hit;
      rf_idx_o    = busy_o ? idx_q : '0;
      rf_wren_o   = (state_q == S_RF_WR);
      rf_wdata_o  = wdata_q;
      mem_req_o   = waiting;
      mem_we_o    = (state_q == S_SAVE);
      mem_addr_o  = {slot_q, rf_idx_o};
      mem_wdata_o = (state_q == S_SAVE) ? rf_rdata_i : 32'd0;
      state_o     = state_q;
   end

endmodule

// File: tb/tb_regfile_ctx_ctrl.sv
// Bench for regfile_ctx_ctrl: register-file and backing-store models, a table of
// save/restore vectors, randomized-latency operations and a mid-transfer reset.
module tb_regfile_ctx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_save, start_restore;
  logic [4:0]  slot;
  logic        busy, stall_cpu, done, err;
  logic [4:0]  rf_idx;
  logic [31:0] rf_rdata;
  logic        rf_wren;
  logic [31:0] rf_wdata;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [2:0]  state;

  regfile_ctx_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_save_i   (start_save),
    .start_restore_i(start_restore),
    .slot_i         (slot),
    .busy_o         (busy),
    .stall_cpu_o    (stall_cpu),
    .done_o         (done),
    .err_o          (err),
    .rf_idx_o       (rf_idx),
    .rf_rdata_i     (rf_rdata),
    .rf_wren_o      (rf_wren),
    .rf_wdata_o     (rf_wdata),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_ack_i      (mem_ack),
    .mem_rdata_i    (mem_rdata),
    .state_o        (state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- environment models ----------------
  logic [31:0] rf [32];
  logic [31:0] mem [1024];
  logic [41:0] obs_q[$];
  int init_gen = 0, seen_gen = 0;
  int fixed_lat = 0;
  bit rand_lat = 1'b0;
  int cur_lat = 0, wait_cnt = 0, lat_sum = 0, wren_cnt = 0;
  bit in_req = 1'b0, pend = 1'b0, pend_we = 1'b0;
  logic [9:0]  pend_addr = '0;
  logic [31:0] pend_data = '0;

  assign rf_rdata = rf[rf_idx];

  always @(posedge clk or negedge clk) begin
    if (clk) begin
      if (pend && rst_n) begin
        if (pend_we) begin
          mem[pend_addr] = pend_data;
          obs_q.push_back({pend_addr, pend_data});
        end
        lat_sum += cur_lat;
        in_req   = 1'b0;
        wait_cnt = 0;
      end
      pend = 1'b0;
    end else begin
      if (init_gen != seen_gen) begin
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'hDEAD_0000 : 32'h100 + 32'(i);
        for (int a = 0; a < 1024; a++) mem[a] = $urandom;
        seen_gen = init_gen;
      end
      if (!rst_n) begin
        mem_ack  = 1'b0;
        in_req   = 1'b0;
        wait_cnt = 0;
      end else begin
        if (rf_wren) begin
          rf[rf_idx] = rf_wdata;
          wren_cnt++;
        end
        if (mem_req) begin
          if (!in_req) begin
            in_req   = 1'b1;
            wait_cnt = 0;
            cur_lat  = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
          end
          if (wait_cnt >= cur_lat) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
            pend      = 1'b1;
            pend_we   = mem_we;
            pend_addr = mem_addr;
            pend_data = mem_wdata;
          end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            wait_cnt++;
          end
        end else begin
          mem_ack = 1'b0;
          in_req  = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int op;       // 0 save, 1 restore, 2 both starts together
    int slot;
    int lat;      // fixed ack latency in wait cycles
    bit rnd;      // per-request random latency 0..3
    int inj;      // cycle at which a stray start_restore is pulsed (0 = none)
    bit exp_err;
    int exp_cyc;  // cycle of done (or err) counted from the first busy cycle
  } vec_t;

  task automatic run_vec(input vec_t v, input bit use_model, input string tag);
    int w0, l0, o0, c, done_c, err_c, exp_c, exp_wr;
    bit is_save;
    logic [41:0] exp_q[$];
    logic [31:0] exp_rf [32];
    w0 = wren_cnt; l0 = lat_sum; o0 = obs_q.size();
    done_c = 0; err_c = 0;
    is_save = (v.op != 1);
    for (int i = 1; i < 32; i++) begin
      if (is_save) exp_q.push_back({5'(v.slot), 5'(i), rf[i]});
      exp_rf[i] = mem[{5'(v.slot), 5'(i)}];
    end
    fixed_lat = v.lat;
    rand_lat  = v.rnd;
    @(negedge clk);
    start_save    = (v.op == 0 || v.op == 2);
    start_restore = (v.op == 1 || v.op == 2);
    slot          = 5'(v.slot);
    @(negedge clk);
    start_save    = 1'b0;
    start_restore = 1'b0;
    slot          = 5'($urandom);
    c = 1;
    while (c < 1000) begin
      start_restore = (c == v.inj);
      if (done) begin done_c = c; break; end
      if (err)  begin err_c  = c; break; end
      @(negedge clk);
      c++;
    end
    start_restore = 1'b0;
    @(negedge clk);
    chk({tag, " busy_after"}, busy, 0);
    chk({tag, " stall_after"}, stall_cpu, 0);
    chk({tag, " mem_req_after"}, mem_req, 0);
    chk({tag, " done_after"}, done, 0);
    if (v.exp_err) begin
      chk({tag, " err_cycle"}, err_c, v.exp_cyc);
      chk({tag, " no_done"}, done_c, 0);
      exp_wr = 0;
    end else begin
      exp_c = use_model ? (lat_sum - l0) + 31 * (is_save ? 1 : 2) + 1 : v.exp_cyc;
      chk({tag, " done_cycle"}, done_c, exp_c);
      chk({tag, " no_err"}, err_c, 0);
      exp_wr = is_save ? 31 : 0;
    end
    chk({tag, " write_count"}, obs_q.size() - o0, exp_wr);
    for (int k = 0; k < exp_wr; k++)
      if (o0 + k < obs_q.size())
        chk($sformatf("%s write[%0d]", tag, k + 1), obs_q[o0 + k], exp_q[k]);
    if (!is_save && !v.exp_err) begin
      for (int i = 1; i < 32; i++) chk($sformatf("%s rf[%0d]", tag, i), rf[i], exp_rf[i]);
      chk({tag, " r0_untouched"}, rf[0], 32'hDEAD_0000);
      chk({tag, " wren_pulses"}, wren_cnt - w0, 31);
    end else begin
      chk({tag, " wren_pulses"}, wren_cnt - w0, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  vec_t vecs[9];
  vec_t rv;
  int c;

  initial begin
    vecs[0] = '{op: 0, slot: 3,  lat: 0,    rnd: 0, inj: 0, exp_err: 0, exp_cyc: 32};
    vecs[1] = '{op: 1, slot: 3,  lat: 2,    rnd: 0, inj: 0, exp_err: 0, exp_cyc: 125};
    vecs[2] = '{op: 2, slot: 7,  lat: 0,    rnd: 0, inj: 0, exp_err: 0, exp_cyc: 32};
    vecs[3] = '{op: 0, slot: 12, lat: 1,    rnd: 0, inj: 5, exp_err: 0, exp_cyc: 63};
    vecs[4] = '{op: 1, slot: 0,  lat: 0,    rnd: 0, inj: 0, exp_err: 0, exp_cyc: 63};
    vecs[5] = '{op: 0, slot: 31, lat: 3,    rnd: 0, inj: 0, exp_err: 0, exp_cyc: 125};
    vecs[6] = '{op: 0, slot: 5,  lat: 1000, rnd: 0, inj: 0, exp_err: 1, exp_cyc: 255};
    vecs[7] = '{op: 1, slot: 9,  lat: 1000, rnd: 0, inj: 0, exp_err: 1, exp_cyc: 255};
    vecs[8] = '{op: 1, slot: 31, lat: 1,    rnd: 0, inj: 0, exp_err: 0, exp_cyc: 94};

    rst_n = 1'b0; start_save = 1'b0; start_restore = 1'b0; slot = '0;
    init_gen = 1;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset stall", stall_cpu, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset rf_wren", rf_wren, 0);
    chk("reset mem_req", mem_req, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset rf_wdata", rf_wdata, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset state", state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

    for (int k = 0; k < 6; k++) begin
      rv = '{op: int'($urandom_range(0, 2)), slot: int'($urandom_range(0, 31)), lat: 0,
             rnd: 1, inj: 0, exp_err: 0, exp_cyc: 0};
      run_vec(rv, 1'b1, $sformatf("rand%0d", k));
    end

    // Reset in the middle of a restore, then a fresh save must start from r1.
    fixed_lat = 0; rand_lat = 1'b0;
    @(negedge clk);
    start_restore = 1'b1; slot = 5'd3;
    @(negedge clk);
    start_restore = 1'b0;
    c = 0;
    while (rf_idx != 5'd10 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("midrst reach_idx10", rf_idx, 10);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst stall", stall_cpu, 0);
    chk("midrst done", done, 0);
    chk("midrst err", err, 0);
    chk("midrst rf_wren", rf_wren, 0);
    chk("midrst mem_req", mem_req, 0);
    chk("midrst mem_we", mem_we, 0);
    chk("midrst rf_idx", rf_idx, 0);
    chk("midrst rf_wdata", rf_wdata, 0);
    chk("midrst mem_addr", mem_addr, 0);
    chk("midrst mem_wdata", mem_wdata, 0);
    chk("midrst state", state, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rv = '{op: 0, slot: 4, lat: 0, rnd: 0, inj: 0, exp_err: 0, exp_cyc: 32};
    run_vec(rv, 1'b0, "post_reset_save");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
